// File: rtl/lane_merge_pkg.sv
// lane_merge_pkg: shared definitions for the two-lane receive merge stage.
//   - merge FSM state encoding
//   - default widths/depths used by lane_merge and lane_fifo
package lane_merge_pkg;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int FIFO_DEPTH_DEF   = 4;
  localparam int ADDR_WIDTH_DEF   = 2;
  localparam int SKEW_TIMEOUT_DEF = 8;
  localparam int NUM_LANES        = 2;

  // Stall counter is sized for the largest legal timeout (255).
  localparam int STALL_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ERROR = 2'd2
  } state_t;

endpackage

// File: rtl/lane_fifo.sv
// lane_fifo: per-lane synchronous FIFO.
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   push, din         - write din at the tail
//   pop               - drop the head entry
//   flush             - empty the FIFO (wins over push/pop)
//   head              - current head entry (valid when !empty)
//   full, empty       - derived from the registered count
//   count             - number of entries held, 0..FIFO_DEPTH
// The caller guarantees push only when not full or when popping the same
// cycle, and pop only when not empty.
module lane_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;

  // Storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers are exactly ADDR_WIDTH bits, so wrap modulo FIFO_DEPTH is free.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (ADDR_WIDTH+1)'(1);
        2'b01:   cnt <= cnt - (ADDR_WIDTH+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/lane_merge.sv
// lane_merge: re-interleaves the two phy lanes into one byte stream.
// Each lane is buffered in a lane_fifo; bytes are taken strictly round-robin
// (lane 0, lane 1, lane 0, ...) into a registered valid/ready output.
// Ports:
//   clk_2f, reset              - clock, synchronous active-high reset
//   valid_in_0/1, data_in_0/1  - per-lane bytes from the phy
//   ready_out                  - consumer accepts data_out this cycle
//   valid_out, data_out        - merged stream (registered)
//   fifo_full_0/1, fifo_empty_0/1 - per-lane FIFO occupancy flags
//   overflow                   - sticky: a byte was dropped on a full FIFO
//   desync                     - sticky: lanes skewed past SKEW_TIMEOUT
module lane_merge
  import lane_merge_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int SKEW_TIMEOUT = SKEW_TIMEOUT_DEF
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic                  valid_in_0,
  input  logic [DATA_WIDTH-1:0] data_in_0,
  input  logic                  valid_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic                  ready_out,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  fifo_full_0,
  output logic                  fifo_full_1,
  output logic                  fifo_empty_0,
  output logic                  fifo_empty_1,
  output logic                  overflow,
  output logic                  desync
);

  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(SKEW_TIMEOUT - 1);

  logic [NUM_LANES-1:0]                 lane_vld, lane_push, lane_pop, lane_drop;
  logic [NUM_LANES-1:0]                 lane_full, lane_empty;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_din, lane_head;
  logic [NUM_LANES-1:0][ADDR_WIDTH:0]   lane_cnt;

  state_t             state;
  logic               sel;
  logic [STALL_W-1:0] stall_cnt;

  logic out_free, load, stall_hit, to_error, any_push, all_empty;

  assign lane_vld = {valid_in_1, valid_in_0};
  assign lane_din = {data_in_1, data_in_0};

  // Output register can take a byte if empty or being drained this cycle.
  // Strict ordering: only the selected lane is ever considered.
  assign out_free = !valid_out || ready_out;
  assign load     = out_free && (state != ERROR) && !lane_empty[sel];

  // Skew: the lane we wait on is empty while the other has filled up.
  assign stall_hit = (state == RUN) && lane_empty[sel] && lane_full[~sel];
  assign to_error  = stall_hit && (stall_cnt == STALL_LAST);

  assign any_push  = |lane_push;
  assign all_empty = ((lane_cnt[0] | lane_cnt[1]) == '0);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    // A full FIFO still accepts a byte when its head leaves the same cycle.
    // In ERROR the lanes are deaf: nothing written, nothing flagged.
    assign lane_pop[i]  = load && (sel == (i == 1));
    assign lane_push[i] = lane_vld[i] && (state != ERROR) &&
                          (!lane_full[i] || lane_pop[i]);
    assign lane_drop[i] = lane_vld[i] && (state != ERROR) && !lane_push[i];

    lane_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
      .clk   (clk_2f),
      .reset (reset),
      .push  (lane_push[i]),
      .pop   (lane_pop[i]),
      .flush (to_error),
      .din   (lane_din[i]),
      .head  (lane_head[i]),
      .full  (lane_full[i]),
      .empty (lane_empty[i]),
      .count (lane_cnt[i])
    );
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= 1'b0;
      stall_cnt <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      overflow  <= 1'b0;
      desync    <= 1'b0;
    end else begin
      if (|lane_drop) overflow <= 1'b1;

      stall_cnt <= (stall_hit && !to_error) ? stall_cnt + STALL_W'(1) : '0;

      case (state)
        IDLE:    if (any_push) state <= RUN;
        RUN: begin
          if (to_error) begin
            state  <= ERROR;
            desync <= 1'b1;
          end else if (all_empty && !valid_out && !any_push) begin
            state <= IDLE;
          end
        end
        ERROR:   if (!valid_in_0 && !valid_in_1) state <= IDLE;
        default: state <= IDLE;
      endcase

      // Entering ERROR abandons any pending byte and restarts at lane 0;
      // the FIFOs are flushed by the same to_error strobe.
      if (to_error) begin
        valid_out <= 1'b0;
        sel       <= 1'b0;
      end else if (load) begin
        data_out  <= lane_head[sel];
        valid_out <= 1'b1;
        sel       <= ~sel;
      end else if (valid_out && ready_out) begin
        valid_out <= 1'b0;
      end
    end
  end

  assign fifo_full_0  = lane_full[0];
  assign fifo_full_1  = lane_full[1];
  assign fifo_empty_0 = lane_empty[0];
  assign fifo_empty_1 = lane_empty[1];

endmodule
